// File: rtl/multi_clock_divider.sv
// NUM_CH independent programmable clock dividers sharing one board clock.
// Each channel emits a 50%-duty divided clock plus a tick on every rising edge.
module multi_clock_divider #(
  parameter int NUM_CH       = 4,
  parameter int WIDTH        = 26,
  parameter int DEFAULT_HALF = 25_000_000,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [WIDTH-1:0]  cfg_half,
  output logic [NUM_CH-1:0] cfg_busy,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             busy_q, busy_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             sel;
    logic             running;
    logic             wrap;

    // An index beyond NUM_CH-1 never matches any channel, so such writes are dropped.
    assign sel     = cfg_we && (cfg_ch == CH_W'(i));
    assign running = ch_en[i] && (active_q != '0);
    assign wrap    = running && (cnt_q == active_q - WIDTH'(1));

    always_comb begin
      cnt_d     = cnt_q;
      active_d  = active_q;
      pending_d = sel ? cfg_half : pending_q;
      busy_d    = busy_q;
      clk_d     = clk_q;
      tick_d    = 1'b0;
      if (!running) begin
        // Idle channels take new values at once; nothing is left to finish.
        cnt_d    = '0;
        clk_d    = 1'b0;
        busy_d   = 1'b0;
        active_d = sel ? cfg_half : pending_q;
      end else if (sync) begin
        cnt_d    = '0;
        clk_d    = 1'b0;
        busy_d   = 1'b0;
        active_d = sel ? cfg_half : pending_q;
      end else if (wrap) begin
        // A half-period of zero being installed parks the output low rather than
        // emitting a one-cycle rise before the channel stops.
        cnt_d    = '0;
        clk_d    = (pending_q != '0) && !clk_q;
        tick_d   = (pending_q != '0) && !clk_q;
        active_d = pending_q;
        busy_d   = sel;
      end else begin
        cnt_d  = cnt_q + WIDTH'(1);
        busy_d = busy_q || sel;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q     <= '0;
        active_q  <= WIDTH'(DEFAULT_HALF);
        pending_q <= WIDTH'(DEFAULT_HALF);
        busy_q    <= 1'b0;
        clk_q     <= 1'b0;
        tick_q    <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        active_q  <= active_d;
        pending_q <= pending_d;
        busy_q    <= busy_d;
        clk_q     <= clk_d;
        tick_q    <= tick_d;
      end
    end

    assign clk_out[i]  = clk_q;
    assign tick[i]     = tick_q;
    assign cfg_busy[i] = busy_q;
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed bench for multi_clock_divider: expected samples are queued by cycle
// number as stimulus is issued and a negedge monitor compares them.
module tb_multi_clock_divider;

  localparam int NUM_CH = 3;
  localparam int WIDTH  = 8;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] ch_en;
  logic              sync;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [WIDTH-1:0]  cfg_half;
  logic [NUM_CH-1:0] cfg_busy;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;

  // Three channels so that cfg_ch = 3 is a genuinely absent index.
  multi_clock_divider #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEFAULT_HALF(4)) dut (
    .clk(clk), .reset(reset), .ch_en(ch_en), .sync(sync), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_half(cfg_half), .cfg_busy(cfg_busy),
    .clk_out(clk_out), .tick(tick)
  );

  always #5 clk = ~clk;

  localparam int K_CLK = 0, K_TICK = 1, K_BUSY = 2;

  typedef struct {
    int   cyc;
    int   kind;
    int   ch;
    logic val;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   checks   = 0;
  int   failures = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check_val(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("[TB] FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, want);
    end
  endtask

  task automatic push_exp(input int at, input int kind, input int ch, input logic val);
    exp_t e;
    int   idx;
    e   = '{at, kind, ch, val};
    idx = sb.size();
    for (int k = 0; k < sb.size(); k++) begin
      if (sb[k].cyc > at) begin
        idx = k;
        break;
      end
    end
    sb.insert(idx, e);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        exp_t e;
        logic act;
        string nm;
        e = sb.pop_front();
        case (e.kind)
          K_CLK:   begin act = clk_out[e.ch];  nm = $sformatf("clk_out[%0d]", e.ch);  end
          K_TICK:  begin act = tick[e.ch];     nm = $sformatf("tick[%0d]", e.ch);     end
          default: begin act = cfg_busy[e.ch]; nm = $sformatf("cfg_busy[%0d]", e.ch); end
        endcase
        if (e.cyc < cyc) check_val({nm, " late"}, cyc, e.cyc);
        else             check_val(nm, int'(act), int'(e.val));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_cyc(input int n);
    for (int k = 0; k < 2000 && cyc < n; k++) step();
    if (cyc != n) begin
      failures++;
      $display("[TB] FAIL wait_cyc got=%0d want=%0d", cyc, n);
    end
  endtask

  task automatic cfg_write(input int ch, input int h);
    cfg_we   = 1'b1;
    cfg_ch   = CH_W'(ch);
    cfg_half = WIDTH'(h);
    step();
    cfg_we   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1'b1; ch_en = 3'b011; sync = 1'b0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_half = '0;
    #12;
    check_val("reset clk_out", int'(clk_out), 0);
    check_val("reset tick", int'(tick), 0);
    check_val("reset cfg_busy", int'(cfg_busy), 0);
    @(posedge clk);
    #2 reset = 1'b0;

    // Default half-period 4 on both enabled channels.
    push_exp(1, K_BUSY, 0, 0);
    push_exp(3, K_CLK, 0, 0);  push_exp(4, K_CLK, 0, 1);  push_exp(4, K_TICK, 0, 1);
    push_exp(5, K_TICK, 0, 0); push_exp(5, K_CLK, 0, 1);  push_exp(7, K_CLK, 0, 1);
    push_exp(4, K_CLK, 1, 1);  push_exp(4, K_TICK, 1, 1); push_exp(8, K_CLK, 1, 0);
    push_exp(8, K_TICK, 1, 0); push_exp(12, K_CLK, 1, 1); push_exp(12, K_TICK, 1, 1);
    push_exp(6, K_CLK, 2, 0);

    wait_cyc(5);
    push_exp(6, K_BUSY, 0, 1);  push_exp(7, K_BUSY, 0, 1);  push_exp(7, K_CLK, 0, 1);
    push_exp(8, K_BUSY, 0, 0);  push_exp(8, K_CLK, 0, 0);   push_exp(9, K_CLK, 0, 0);
    push_exp(10, K_CLK, 0, 1);  push_exp(10, K_TICK, 0, 1); push_exp(11, K_CLK, 0, 1);
    push_exp(11, K_TICK, 0, 0); push_exp(12, K_CLK, 0, 0);  push_exp(13, K_CLK, 0, 0);
    push_exp(14, K_CLK, 0, 1);  push_exp(14, K_TICK, 0, 1);
    cfg_write(0, 2);

    wait_cyc(14);
    push_exp(15, K_BUSY, 1, 1); push_exp(15, K_CLK, 1, 1);  push_exp(16, K_BUSY, 1, 0);
    push_exp(16, K_CLK, 1, 0);  push_exp(16, K_TICK, 1, 0); push_exp(18, K_CLK, 1, 0);
    push_exp(20, K_CLK, 1, 0);  push_exp(24, K_CLK, 1, 0);  push_exp(24, K_TICK, 1, 0);
    push_exp(18, K_TICK, 0, 1); push_exp(20, K_CLK, 0, 0);
    cfg_write(1, 0);

    wait_cyc(25);
    push_exp(26, K_BUSY, 1, 0); push_exp(26, K_CLK, 1, 0);  push_exp(28, K_CLK, 1, 0);
    push_exp(28, K_TICK, 1, 0); push_exp(29, K_CLK, 1, 1);  push_exp(29, K_TICK, 1, 1);
    cfg_write(1, 3);

    wait_cyc(30);
    push_exp(31, K_BUSY, 0, 1); push_exp(32, K_BUSY, 0, 0); push_exp(32, K_CLK, 0, 0);
    cfg_write(0, 4);
    push_exp(32, K_CLK, 1, 0);  push_exp(32, K_BUSY, 1, 1); push_exp(33, K_BUSY, 1, 1);
    cfg_write(1, 4);

    wait_cyc(33);
    push_exp(34, K_CLK, 0, 0);  push_exp(34, K_CLK, 1, 0);  push_exp(34, K_BUSY, 1, 0);
    push_exp(37, K_CLK, 0, 0);  push_exp(37, K_CLK, 1, 0);  push_exp(38, K_CLK, 0, 1);
    push_exp(38, K_CLK, 1, 1);  push_exp(38, K_TICK, 0, 1); push_exp(38, K_TICK, 1, 1);
    push_exp(39, K_TICK, 0, 0); push_exp(39, K_TICK, 1, 0);
    sync = 1'b1;
    step();
    sync = 1'b0;

    wait_cyc(39);
    push_exp(40, K_CLK, 1, 0);  push_exp(41, K_CLK, 1, 0);  push_exp(45, K_CLK, 1, 0);
    push_exp(49, K_CLK, 1, 0);  push_exp(44, K_TICK, 1, 0); push_exp(46, K_TICK, 0, 1);
    ch_en = 3'b001;
    wait_cyc(49);
    push_exp(52, K_CLK, 1, 0);  push_exp(53, K_CLK, 1, 1);  push_exp(53, K_TICK, 1, 1);
    ch_en = 3'b011;

    wait_cyc(55);
    push_exp(56, K_BUSY, 0, 1); push_exp(57, K_BUSY, 0, 1); push_exp(57, K_CLK, 0, 1);
    push_exp(58, K_CLK, 0, 0);  push_exp(58, K_BUSY, 0, 0); push_exp(59, K_CLK, 0, 1);
    push_exp(59, K_TICK, 0, 1); push_exp(60, K_CLK, 0, 0);  push_exp(60, K_TICK, 0, 0);
    push_exp(61, K_CLK, 0, 1);  push_exp(61, K_TICK, 0, 1);
    cfg_write(0, 1);

    wait_cyc(61);
    push_exp(62, K_BUSY, 0, 0); push_exp(62, K_BUSY, 1, 0); push_exp(62, K_CLK, 0, 0);
    push_exp(63, K_CLK, 0, 1);  push_exp(63, K_TICK, 0, 1); push_exp(64, K_CLK, 0, 0);
    cfg_write(3, 7);
    push_exp(63, K_BUSY, 1, 1);
    cfg_write(1, 5);
    push_exp(64, K_BUSY, 1, 1); push_exp(65, K_BUSY, 1, 0); push_exp(65, K_CLK, 1, 0);
    push_exp(70, K_CLK, 1, 0);  push_exp(70, K_TICK, 1, 0); push_exp(71, K_CLK, 1, 1);
    push_exp(71, K_TICK, 1, 1);
    cfg_write(1, 6);
    push_exp(65, K_BUSY, 2, 0); push_exp(66, K_BUSY, 2, 0); push_exp(66, K_CLK, 2, 0);
    cfg_write(2, 9);

    wait_cyc(72);
    push_exp(73, K_BUSY, 1, 1);
    cfg_write(1, 2);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check_val("async reset clk_out", int'(clk_out), 0);
    check_val("async reset tick", int'(tick), 0);
    check_val("async reset cfg_busy", int'(cfg_busy), 0);
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL pending before reset got=%0d want=0", sb.size());
    end
    sb.delete();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    push_exp(1, K_BUSY, 1, 0); push_exp(3, K_CLK, 1, 0);  push_exp(3, K_CLK, 0, 0);
    push_exp(4, K_CLK, 0, 1);  push_exp(4, K_CLK, 1, 1);  push_exp(4, K_TICK, 1, 1);
    push_exp(8, K_CLK, 1, 0);
    wait_cyc(9);

    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL unconsumed expectations got=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
